// File: rtl/capture_seq_pkg.sv
// Shared types for the PDH capture sequencer.
package pdh_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    AWAIT_DMA,
    DONE
  } capture_state_t;

  typedef enum logic {
    MODE_IMMEDIATE = 1'b0,
    MODE_TRIGGERED = 1'b1
  } capture_mode_t;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/capture_seq_if.sv
// BRAM write port driven by the capture sequencer.
interface capture_seq_if #(
  parameter int AW = 14,
  parameter int DW = 64
) ();
  logic          bram_we_o;
  logic [AW-1:0] bram_waddr_o;
  logic [DW-1:0] bram_wdata_o;

  modport master (output bram_we_o, bram_waddr_o, bram_wdata_o);
  modport slave  (input  bram_we_o, bram_waddr_o, bram_wdata_o);
endinterface

// File: rtl/capture_seq_decimator.sv
// Decimation counter: strobe when the count is zero, wrap after reaching i_dec.
module capture_decimator #(
  parameter int DECW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [DECW-1:0] i_dec,
  output logic            o_stb
);
  logic [DECW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= (r_cnt == i_dec) ? '0 : r_cnt + DECW'(1);

  assign o_stb = (r_cnt == '0);
endmodule

// File: rtl/posedge_detector.sv
// Rising-edge detector: combinational pulse on the cycle the input is first seen high.
module posedge_detector (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else     r_q <= i_sig;

  assign o_rise = i_sig & ~r_q;
endmodule

// File: rtl/capture_seq.sv
// Capture sequencer: decimated sample stream into a BRAM, immediate or triggered
// with a circular pre-trigger window, then hand-off to DMA readout.
module capture_seq
  import pdh_capture_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 64,
  parameter int DECW  = 16
) (
  input  logic            pdh_clk,
  input  logic            rst_i,
  input  logic            arm_i,
  input  logic            mode_i,
  input  logic            trig_i,
  input  logic [AW:0]     len_i,
  input  logic [AW-1:0]   pretrig_i,
  input  logic [DECW-1:0] dec_i,
  input  logic [DW-1:0]   din_i,
  input  logic            dma_done_i,
  capture_seq_if.master   bram,
  output logic [AW-1:0]   start_addr_o,
  output logic            dma_enable_o,
  output logic            transaction_complete_o,
  output logic            busy_o
);

  if (!is_pow2(DEPTH) || ((1 << AW) != DEPTH)) begin : g_depth_chk
    $error("capture_seq: DEPTH must be a power of two equal to 2**AW");
  end

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  capture_state_t  r_state, w_next;
  capture_mode_t   r_mode;
  logic [DECW-1:0] r_dec;
  logic [AW:0]     r_len, r_rem, w_len_eff, w_len_m1;
  logic [AW-1:0]   r_pre, w_pre_eff, r_waddr, r_start, r_wa;
  logic [DW-1:0]   r_wd;
  logic            r_we;
  logic            w_arm_edge, w_stb, w_start, w_trig, w_wr, w_run;

  posedge_detector u_arm_edge (
    .clk    (pdh_clk),
    .rst    (rst_i),
    .i_sig  (arm_i),
    .o_rise (w_arm_edge)
  );

  assign w_run = (r_state == PRE) || (r_state == ARMED) || (r_state == POST);

  capture_decimator #(.DECW(DECW)) u_dec (
    .clk   (pdh_clk),
    .rst   (rst_i),
    .i_clr (w_start),
    .i_en  (w_run),
    .i_dec (r_dec),
    .o_stb (w_stb)
  );

  // Pre-trigger is clamped to len-1 so at least one post-trigger sample lands.
  assign w_len_eff = (len_i == '0 || len_i > DEPTH_W) ? DEPTH_W : len_i;
  assign w_len_m1  = w_len_eff - (AW+1)'(1);
  assign w_pre_eff = ({1'b0, pretrig_i} > w_len_m1) ? AW'(w_len_m1) : pretrig_i;

  always_ff @(posedge pdh_clk or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_trig  = 1'b0;
    w_wr    = 1'b0;
    case (r_state)
      IDLE, DONE:
        if (w_arm_edge) begin
          w_start = 1'b1;
          if (capture_mode_t'(mode_i) == MODE_IMMEDIATE) w_next = POST;
          else if (w_pre_eff == '0)                       w_next = ARMED;
          else                                            w_next = PRE;
        end
      PRE: begin
        w_wr = w_stb;
        if (w_stb && r_rem == (AW+1)'(1)) w_next = ARMED;
      end
      ARMED: begin
        // A strobe on the trigger cycle still lands as a pre-trigger sample.
        w_wr = w_stb && (r_pre != '0);
        if (trig_i && r_mode == MODE_TRIGGERED) begin
          w_trig = 1'b1;
          w_next = POST;
        end
      end
      POST:
        if (r_rem == '0) w_next = AWAIT_DMA;
        else             w_wr   = w_stb;
      AWAIT_DMA:
        if (dma_done_i) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pdh_clk or posedge rst_i)
    if (rst_i) begin
      r_mode  <= MODE_IMMEDIATE;
      r_dec   <= '0;
      r_len   <= '0;
      r_pre   <= '0;
      r_rem   <= '0;
      r_waddr <= '0;
      r_start <= '0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wa    <= r_waddr;
        r_wd    <= din_i;
        r_waddr <= r_waddr + AW'(1);
      end
      if (w_start) begin
        r_mode  <= capture_mode_t'(mode_i);
        r_dec   <= dec_i;
        r_len   <= w_len_eff;
        r_pre   <= w_pre_eff;
        r_waddr <= '0;
        r_start <= '0;
        r_rem   <= (capture_mode_t'(mode_i) == MODE_IMMEDIATE) ? w_len_eff : {1'b0, w_pre_eff};
      end else if (w_trig) begin
        r_rem   <= r_len - {1'b0, r_pre};
        r_start <= r_waddr + AW'(w_wr) - r_pre;
      end else if (w_wr && r_state != ARMED) begin
        r_rem <= r_rem - (AW+1)'(1);
      end
    end

  assign bram.bram_we_o         = r_we;
  assign bram.bram_waddr_o      = r_wa;
  assign bram.bram_wdata_o      = r_wd;
  assign start_addr_o           = r_start;
  assign dma_enable_o           = (r_state == AWAIT_DMA);
  assign transaction_complete_o = (r_state == DONE);
  assign busy_o                 = w_run || (r_state == AWAIT_DMA);

endmodule

// File: tb/tb_capture_seq.sv
// Randomized bench for capture_seq with a cycle-level behavioural model and directed anchors.
module tb_capture_seq;
  localparam int DEPTH = 32, AW = 5, DW = 16, DECW = 4;
  localparam int P_IDLE = 0, P_PRE = 1, P_ARMED = 2, P_POST = 3, P_AWAIT = 4, P_DONE = 5;

  logic clk = 1'b0, rst = 1'b0, arm = 1'b0, mode = 1'b0, trig = 1'b0, dma_done = 1'b0;
  logic [AW:0]     len = '0;
  logic [AW-1:0]   pre = '0;
  logic [DECW-1:0] dec = '0;
  logic [DW-1:0]   din = '0;
  logic [AW-1:0]   start_addr;
  logic            dma_en, tc, busy;

  capture_seq_if #(.AW(AW), .DW(DW)) bus ();

  capture_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .DECW(DECW)) dut (
    .pdh_clk(clk), .rst_i(rst), .arm_i(arm), .mode_i(mode), .trig_i(trig),
    .len_i(len), .pretrig_i(pre), .dec_i(dec), .din_i(din), .dma_done_i(dma_done),
    .bram(bus), .start_addr_o(start_addr), .dma_enable_o(dma_en),
    .transaction_complete_o(tc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit en_chk = 0;

  // model state
  int m_ph, m_n, m_wc, m_pre_left, m_post_left, m_len, m_pre, m_dec, m_wa, m_wd, m_start;
  bit m_armq, m_imm, m_we;

  // observed writes
  int wa_q[$], wc_q[$];
  logic [DW-1:0] wd_q[$];
  int dma_rise = -1;
  bit dma_prev = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_n = 0; m_wc = 0; m_pre_left = 0; m_post_left = 0; m_len = 0;
    m_pre = 0; m_dec = 0; m_wa = 0; m_wd = 0; m_start = 0; m_armq = 0; m_imm = 0; m_we = 0;
  endtask

  task automatic do_write();
    m_we = 1; m_wa = m_wc % DEPTH; m_wd = int'(din); m_wc++;
  endtask

  function automatic bit strobe();
    return (m_n % (m_dec + 1)) == 0;
  endfunction

  task automatic model_step();
    bit e, s;
    e = arm && !m_armq;
    m_armq = arm;
    m_we = 0;
    case (m_ph)
      P_IDLE, P_DONE:
        if (e) begin
          m_len = (len == 0 || int'(len) > DEPTH) ? DEPTH : int'(len);
          m_pre = (int'(pre) > m_len - 1) ? m_len - 1 : int'(pre);
          m_dec = int'(dec); m_imm = (mode == 1'b0);
          m_n = 0; m_wc = 0; m_start = 0;
          if (m_imm) begin m_ph = P_POST; m_post_left = m_len; end
          else if (m_pre == 0) m_ph = P_ARMED;
          else begin m_ph = P_PRE; m_pre_left = m_pre; end
        end
      P_PRE: begin
        s = strobe(); m_n++;
        if (s) begin
          do_write(); m_pre_left--;
          if (m_pre_left == 0) m_ph = P_ARMED;
        end
      end
      P_ARMED: begin
        s = strobe(); m_n++;
        if (s && m_pre > 0) do_write();
        if (trig) begin
          m_ph = P_POST; m_post_left = m_len - m_pre;
          m_start = (((m_wc - m_pre) % DEPTH) + DEPTH) % DEPTH;
        end
      end
      P_POST:
        if (m_post_left == 0) m_ph = P_AWAIT;
        else begin
          s = strobe(); m_n++;
          if (s) begin do_write(); m_post_left--; end
        end
      P_AWAIT: if (dma_done) m_ph = P_DONE;
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("we",    bus.bram_we_o, m_we);
    chk("waddr", bus.bram_waddr_o, m_wa);
    chk("wdata", bus.bram_wdata_o, m_wd);
    chk("start", start_addr, m_start);
    chk("dma",   dma_en, m_ph == P_AWAIT);
    chk("tc",    tc, m_ph == P_DONE);
    chk("busy",  busy, m_ph >= P_PRE && m_ph <= P_AWAIT);
  endtask

  always @(clk) begin
    if (clk) begin
      cyc++;
      if (rst) model_reset(); else model_step();
    end else begin
      if (rst) model_reset();
      if (en_chk) check_all();
      if (!rst && bus.bram_we_o) begin
        wa_q.push_back(int'(bus.bram_waddr_o)); wc_q.push_back(cyc); wd_q.push_back(bus.bram_wdata_o);
      end
      if (dma_en && !dma_prev) dma_rise = cyc;
      dma_prev = dma_en;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
    din = din + 1'b1;
  endtask

  task automatic wait_dma(input int budget);
    for (int i = 0; i < budget && !dma_en; i++) tick();
    chk("dma_wait", dma_en, 1);
    tick();
  endtask

  task automatic pulse_done();
    dma_done = 1; tick(); dma_done = 0;
    chk("tc_after_done", tc, 1);
  endtask

  task automatic arm_pulse();
    arm = 1; tick(); arm = 0;
  endtask

  initial begin
    int b, a0;
    #1 rst = 1;
    tick(); tick();
    chk("rst_we", bus.bram_we_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_addr, 0);
    en_chk = 1;
    rst = 0;
    tick();

    // immediate, len 8, dec 0
    mode = 0; len = 8; dec = 0; pre = 0;
    b = wa_q.size(); arm = 1; tick(); a0 = cyc; arm = 0;
    wait_dma(40);
    chk("t1_count", wa_q.size() - b, 8);
    chk("t1_first_lat", wc_q[b] - a0, 1);
    chk("t1_addr0", wa_q[b], 0);
    chk("t1_addr7", wa_q[b+7], 7);
    chk("t1_data_span", wd_q[b+7] - wd_q[b], 7);
    chk("t1_consec", wc_q[b+7] - wc_q[b], 7);
    chk("t1_dma_lat", dma_rise - wc_q[b+7], 1);
    pulse_done();

    // immediate, len 4, dec 2
    len = 4; dec = 2;
    b = wa_q.size(); arm_pulse();
    wait_dma(60);
    chk("t2_count", wa_q.size() - b, 4);
    chk("t2_space", wc_q[b+1] - wc_q[b], 3);
    chk("t2_span", wc_q[b+3] - wc_q[b], 9);
    pulse_done();

    // triggered, len 16, pre 4, trigger on the 10th ARMED write
    mode = 1; len = 16; pre = 4; dec = 0; trig = 0;
    b = wa_q.size(); arm_pulse();
    repeat (13) tick();
    trig = 1; tick(); trig = 0;
    wait_dma(60);
    chk("t3_count", wa_q.size() - b, 26);
    chk("t3_start", start_addr, 10);
    chk("t3_addr13", wa_q[b+13], 13);
    chk("t3_addr14", wa_q[b+14], 14);
    chk("t3_addr25", wa_q[b+25], 25);
    pulse_done();

    // triggered, len clamped to DEPTH, pre 0, trigger held
    len = 0; pre = 0; trig = 1;
    b = wa_q.size(); arm_pulse();
    wait_dma(80);
    trig = 0;
    chk("t4_count", wa_q.size() - b, DEPTH);
    chk("t4_start", start_addr, 0);
    chk("t4_addr_first", wa_q[b], 0);
    chk("t4_addr_last", wa_q[b+DEPTH-1], DEPTH - 1);
    pulse_done();

    // arm edges in POST and AWAIT_DMA are ignored; DONE re-arms from 0
    mode = 0; len = 8; dec = 1;
    b = wa_q.size(); arm_pulse();
    repeat (3) tick();
    arm_pulse();
    wait_dma(60);
    chk("t5_count", wa_q.size() - b, 8);
    arm_pulse(); tick();
    chk("t5_await_hold", dma_en, 1);
    pulse_done();
    arm_pulse();
    for (int i = 0; i < 10 && !bus.bram_we_o; i++) tick();
    chk("t5_rearm_addr0", bus.bram_waddr_o, 0);
    tick(); tick();

    // reset mid-POST
    rst = 1; #1;
    chk("t6_busy", busy, 0);
    chk("t6_we", bus.bram_we_o, 0);
    chk("t6_waddr", bus.bram_waddr_o, 0);
    tick(); rst = 0;
    b = wa_q.size();
    repeat (10) tick();
    chk("t6_no_writes", wa_q.size() - b, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) arm = ~arm;
      mode     = 1'($urandom_range(0, 1));
      trig     = ($urandom_range(0, 7) == 0);
      dma_done = ($urandom_range(0, 3) == 0);
      len      = (AW+1)'($urandom_range(0, 40));
      pre      = AW'($urandom_range(0, 31));
      dec      = DECW'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 599) == 0);
      tick();
      din = DW'($urandom);
    end
    rst = 0; trig = 0; dma_done = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
